// File: rtl/multdiv_pkg.sv
// Shared constants for the sequential signed multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/multdiv_seq_twos_negate.sv
// Conditional two's-complement negate: dout = en ? -din : din.
module twos_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/multdiv_seq.sv
// Multicycle signed multiply (shift-add) / divide (restoring) unit with
// sign-magnitude datapath, fixed WIDTH+1 cycle latency and abort-on-restart.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [W2-1:0]    acc_q,    acc_d;
    logic [WIDTH-1:0] opr_q,    opr_d;
    logic             sign_q,   sign_d;
    logic             div_q,    div_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q,    exc_d;
    logic             rdy_q,    rdy_d;
    logic             busy_q,   busy_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [W2-1:0]    div_sh;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH+1:0] div_diff;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    iter_next;
    logic [W2-1:0]    res_in;
    logic [W2-1:0]    res_signed;
    logic             mul_ovf;
    logic             div_zero;
    logic             div_ovf;

    twos_negate #(.W(WIDTH)) u_neg_a (
        .din  (data_operandA),
        .en   (data_operandA[WIDTH-1]),
        .dout (abs_a)
    );

    twos_negate #(.W(WIDTH)) u_neg_b (
        .din  (data_operandB),
        .en   (data_operandB[WIDTH-1]),
        .dout (abs_b)
    );

    twos_negate #(.W(W2)) u_neg_r (
        .din  (res_in),
        .en   (sign_q),
        .dout (res_signed)
    );

    // One iteration of either algorithm; acc holds {hi, lo} for both.
    always_comb begin
        mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opr_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[W2-1:1]};

        div_sh   = {acc_q[W2-2:0], 1'b0};
        div_rem  = {acc_q[W2-1], div_sh[W2-1:WIDTH]};
        div_diff = {1'b0, div_rem} - {2'b00, opr_q};
        div_next = div_diff[WIDTH+1] ? div_sh
                                     : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

        iter_next = div_q ? div_next : mul_next;
        res_in    = div_q ? {WIDTH'(0), iter_next[WIDTH-1:0]} : iter_next;

        mul_ovf  = (res_signed[W2-1:WIDTH-1] != '0) && (res_signed[W2-1:WIDTH-1] != '1);
        div_zero = (opr_q == '0);
        div_ovf  = !sign_q && iter_next[WIDTH-1];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opr_d    = opr_q;
        sign_d   = sign_q;
        div_d    = div_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        case (state_q)
            ST_MUL, ST_DIV: begin
                acc_d = iter_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    if (!div_q) begin
                        result_d = res_signed[WIDTH-1:0];
                        exc_d    = mul_ovf;
                    end else if (div_zero) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = res_signed[WIDTH-1:0];
                        exc_d    = div_ovf;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A start in any state (re)launches; MULT wins if both are asserted.
        if (ctrl_MULT || ctrl_DIV) begin
            state_d = ctrl_MULT ? ST_MUL : ST_DIV;
            cnt_d   = '0;
            div_d   = !ctrl_MULT;
            sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            opr_d   = ctrl_MULT ? abs_a : abs_b;
            acc_d   = {WIDTH'(0), (ctrl_MULT ? abs_b : abs_a)};
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opr_q    <= '0;
            sign_q   <= 1'b0;
            div_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opr_q    <= opr_d;
            sign_q   <= sign_d;
            div_q    <= div_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed cases, reset/abort/restart
// scenarios and randomized operations against a signed-arithmetic model.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference: {exception, result} from plain signed arithmetic.
    function automatic logic [32:0] model(input bit mul, input logic [31:0] a, input logic [31:0] b);
        int signed     sa;
        int signed     sb;
        int signed     lo;
        int signed     q;
        longint signed p;
        logic [31:0]   r;
        sa = a;
        sb = b;
        if (mul) begin
            p  = longint'(sa) * longint'(sb);
            lo = int'(p);
            r  = lo;
            return {p != longint'(lo), r};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = sa / sb;
        r = q;
        return {1'b0, r};
    endfunction

    task automatic start_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = !mul;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Counts edges after the sampling edge until ready; 0 means timeout.
    task automatic wait_rdy(output int cyc, output bit busy_ok);
        busy_ok = (busy === 1'b1);
        cyc     = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                cyc = i;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        #1;
        n_tests++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b, want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [11];
        logic [31:0] tb [11];
        bit          tm [11];
        logic [31:0] er [11];
        bit          ee [11];
        int          cyc;
        bit          bok;
        ta = '{32'd7, 32'h0001_0000, 32'h7FFF_FFFF, 32'hFFFF_FF9C, 32'd100, 32'd5,
               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0};
        tb = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1, 32'd7, 32'hFFFF_FFF9, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF};
        tm = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        er = '{32'hFFFF_FFD6, 32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd0,
               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0};
        ee = '{0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            start_op(tm[i], ta[i], tb[i]);
            wait_rdy(cyc, bok);
            n_tests++;
            if (cyc != 33 || !bok) begin
                n_fail++;
                $display("FAIL directed%0d_latency: got cyc=%0d busy_ok=%b, want 33/1", i, cyc, bok);
            end
            n_tests++;
            if (data_result !== er[i] || data_exception !== ee[i]) begin
                n_fail++;
                $display("FAIL directed%0d_value: got %h/%b, want %h/%b",
                         i, data_result, data_exception, er[i], ee[i]);
            end
            @(posedge clock);
            #1;
            n_tests++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== er[i]) begin
                n_fail++;
                $display("FAIL directed%0d_hold: got rdy=%b busy=%b res=%h, want 0/0/%h",
                         i, data_resultRDY, busy, data_result, er[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int cyc;
        bit bok;
        start_op(1'b1, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL midop_reset: got res=%h exc=%b rdy=%b busy=%b, want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        wait_rdy(cyc, bok);
        n_tests++;
        if (cyc != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_ready: got ready at cyc=%0d busy=%b, want none/0", cyc, busy);
        end
        start_op(1'b1, 32'd3, 32'd4);
        wait_rdy(cyc, bok);
        n_tests++;
        if (cyc != 33 || data_result !== 32'd12 || data_exception !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_mult: got cyc=%0d res=%h exc=%b, want 33/0000000c/0",
                     cyc, data_result, data_exception);
        end
    endtask

    task automatic test_abort();
        int cyc;
        bit bok;
        bit early;
        early = 1'b0;
        start_op(1'b0, 32'd50, 32'd5);
        for (int i = 0; i < 13; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY !== 1'b0) early = 1'b1;
        end
        start_op(1'b1, 32'd2, 32'd3);
        wait_rdy(cyc, bok);
        n_tests++;
        if (early || cyc != 33 || !bok) begin
            n_fail++;
            $display("FAIL abort_latency: got early=%b cyc=%0d busy_ok=%b, want 0/33/1", early, cyc, bok);
        end
        n_tests++;
        if (data_result !== 32'd6 || data_exception !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_value: got %h/%b, want 00000006/0", data_result, data_exception);
        end
    endtask

    // New start issued in the DONE cycle of the previous operation.
    task automatic test_back_to_back();
        logic [32:0] e1;
        logic [32:0] e2;
        int          cyc;
        bit          bok;
        e1 = model(1'b0, 32'hFFFF_F000, 32'd9);
        e2 = model(1'b1, 32'h0000_1234, 32'hFFFF_0010);
        start_op(1'b0, 32'hFFFF_F000, 32'd9);
        repeat (32) @(posedge clock);
        #1;
        data_operandA = 32'h0000_1234;
        data_operandB = 32'hFFFF_0010;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        n_tests++;
        if (data_resultRDY !== 1'b1 || {data_exception, data_result} !== e1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got rdy=%b busy=%b %b/%h, want 1/1 %b/%h",
                     data_resultRDY, busy, data_exception, data_result, e1[32], e1[31:0]);
        end
        wait_rdy(cyc, bok);
        n_tests++;
        if (cyc != 33 || {data_exception, data_result} !== e2) begin
            n_fail++;
            $display("FAIL b2b_second: got cyc=%0d %b/%h, want 33 %b/%h",
                     cyc, data_exception, data_result, e2[32], e2[31:0]);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 200));
            5:       return -32'($urandom_range(1, 200));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp_v;
        bit          mul;
        int          cyc;
        bit          bok;
        for (int i = 0; i < 30; i++) begin
            a     = pick_operand();
            b     = pick_operand();
            mul   = ($urandom_range(0, 1) == 1);
            exp_v = model(mul, a, b);
            start_op(mul, a, b);
            wait_rdy(cyc, bok);
            n_tests++;
            if (cyc != 33 || !bok || {data_exception, data_result} !== exp_v) begin
                n_fail++;
                $display("FAIL random%0d %s a=%h b=%h: got cyc=%0d busy_ok=%b %b/%h, want 33/1 %b/%h",
                         i, mul ? "mul" : "div", a, b, cyc, bok,
                         data_exception, data_result, exp_v[32], exp_v[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midop();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
